// File: rtl/divider_step_controller.sv
// Step sequencer for adjustable_frequency_divider: walks the divider upward one setting at a time
// toward a requested index (or sweeps autonomously), spacing pulses so each output period completes.
module divider_step_controller #(
  parameter int unsigned NUM_SETTINGS  = 8,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DWELL_W       = 16
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [IDX_W-1:0]   req_index,
  output logic               req_ready,
  input  logic               sweep_en,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic               step_divisor,
  output logic [IDX_W-1:0]   current_index,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned CntW    = (DWELL_W > SettleW) ? DWELL_W : SettleW;

  localparam logic [IDX_W-1:0] MaxIdx     = IDX_W'(NUM_SETTINGS - 1);
  localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStep, StSettle, StDwell} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  tgt_q, tgt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sweep_q, sweep_d;
  logic              done_q, done_d;
  logic              step_q;
  logic [IDX_W-1:0]  req_clamped;
  logic [IDX_W-1:0]  cur_inc;

  assign req_clamped = (req_index > MaxIdx) ? MaxIdx : req_index;
  assign cur_inc     = (cur_q == MaxIdx) ? '0 : cur_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    sweep_d = sweep_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A pending request always wins over starting another sweep step.
        if (req_valid) begin
          tgt_d   = req_clamped;
          sweep_d = 1'b0;
          if (req_clamped == cur_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StStep;
          end
        end else if (sweep_en) begin
          tgt_d   = cur_inc;
          sweep_d = 1'b1;
          state_d = StStep;
        end
      end
      StStep: begin
        cur_d   = cur_inc;
        cnt_d   = SettleLoad;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cur_q != tgt_q) begin
          state_d = StStep;
        end else if (sweep_q) begin
          cnt_d   = CntW'(dwell_cycles);
          state_d = StDwell;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StDwell: begin
        // Hold for dwell_cycles cycles; a count of 0 still leaves after one cycle.
        if (!sweep_en || cnt_q <= CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      sweep_q <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      sweep_q <= sweep_d;
      done_q  <= done_d;
      step_q  <= (state_d == StStep);
    end
  end

  assign step_divisor  = step_q;
  assign current_index = cur_q;
  assign done          = done_q;
  assign req_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_divider_step_controller.sv
// Directed/randomized bench for divider_step_controller; expected timing is derived from
// pulse-schedule arithmetic (distance, settle period, dwell period).
`timescale 1ns/1ps
module tb_divider_step_controller;

  localparam int N  = 8;
  localparam int IW = 4;
  localparam int S  = 16;
  localparam int DW = 16;
  localparam int P  = S + 1;

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [IW-1:0] req_index = '0;
  logic          req_ready;
  logic          sweep_en = 1'b0;
  logic [DW-1:0] dwell_cycles = '0;
  logic          step_divisor;
  logic [IW-1:0] current_index;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;
  int m_idx    = 0;

  divider_step_controller #(
    .NUM_SETTINGS (N),
    .IDX_W        (IW),
    .SETTLE_CYCLES(S),
    .DWELL_W      (DW)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_index    (req_index),
    .req_ready    (req_ready),
    .sweep_en     (sweep_en),
    .dwell_cycles (dwell_cycles),
    .step_divisor (step_divisor),
    .current_index(current_index),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Issue a request and follow it cycle by cycle; stops early after max_c cycles.
  task automatic run_request(input int idx, input int max_c, input int exp_wait);
    int waited, t, d, done_c, np;
    logic exp_step;
    req_valid = 1'b1;
    req_index = IW'(idx);
    waited = 0;
    while (req_ready !== 1'b1 && waited < 500) begin
      @(negedge clock_in);
      waited++;
    end
    if (exp_wait >= 0) check("accept_wait", waited, exp_wait);
    else check("accept_ready", {31'd0, req_ready}, 1);
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    t = (idx > N - 1) ? N - 1 : idx;
    d = (t + N - m_idx) % N;
    done_c = (d == 0) ? 1 : d * P + 1;
    @(negedge clock_in);
    req_valid = 1'b0;
    sweep_en  = 1'b0;
    for (int c = 1; c <= done_c && c <= max_c; c++) begin
      if (d == 0 || c < 2) np = 0;
      else np = ((c - 2) / P + 1 > d) ? d : (c - 2) / P + 1;
      exp_step = (d != 0) && (c <= (d - 1) * P + 1) && ((c - 1) % P == 0);
      check("req_step", {31'd0, step_divisor}, {31'd0, exp_step});
      check("req_index", {28'd0, current_index}, (m_idx + np) % N);
      check("req_done", {31'd0, done}, (c == done_c) ? 1 : 0);
      check("req_ready", {31'd0, req_ready}, (c == done_c) ? 1 : 0);
      check("req_busy", {31'd0, busy}, (c == done_c) ? 0 : 1);
      if (c < done_c && c < max_c) @(negedge clock_in);
    end
    if (max_c >= done_c) begin
      m_idx = t;
      @(negedge clock_in);
      check("done_single", {31'd0, done}, 0);
    end
  endtask

  initial begin
    int dwell, p2, last;
    logic exp_step;

    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    check("rst_step", {31'd0, step_divisor}, 0);
    check("rst_index", {28'd0, current_index}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_ready", {31'd0, req_ready}, 1);
    m_idx = 0;

    run_request(3, 1000, -1);   // 3 pulses, done at 52
    run_request(6, 1000, -1);
    run_request(2, 1000, -1);   // 6 -> 2 wraps: 4 pulses, done at 69
    run_request(2, 1000, -1);   // same index: done at 1, no pulse
    run_request(12, 1000, -1);  // clamped to 7
    run_request(1, 1000, -1);   // 7 -> 0 -> 1
    repeat (4) run_request(int'($urandom_range(0, 15)), 1000, -1);

    // Autonomous sweep, then a request raised mid-DWELL preempts at the next IDLE cycle.
    dwell = int'($urandom_range(1, 8));
    p2 = S + dwell + 2;
    last = 2 * p2 + 18;
    dwell_cycles = DW'(dwell);
    sweep_en = 1'b1;
    @(negedge clock_in);
    for (int c = 1; c <= last; c++) begin
      exp_step = ((c - 1) % p2 == 0);
      check("swp_step", {31'd0, step_divisor}, {31'd0, exp_step});
      check("swp_index", {28'd0, current_index}, (m_idx + ((c < 2) ? 0 : (c - 2) / p2 + 1)) % N);
      check("swp_busy", {31'd0, busy}, (c % p2 == 0) ? 0 : 1);
      check("swp_done", {31'd0, done}, 0);
      if (c < last) @(negedge clock_in);
    end
    m_idx = (m_idx + 3) % N;
    run_request(int'($urandom_range(0, 7)), 1000, dwell);

    // Dropping sweep_en during DWELL returns to IDLE without restarting.
    dwell_cycles = DW'(8);
    sweep_en = 1'b1;
    @(negedge clock_in);
    for (int c = 1; c <= 20; c++) begin
      exp_step = (c == 1);
      check("drop_step", {31'd0, step_divisor}, {31'd0, exp_step});
      if (c < 20) @(negedge clock_in);
    end
    sweep_en = 1'b0;
    m_idx = (m_idx + 1) % N;
    @(negedge clock_in);
    check("drop_ready", {31'd0, req_ready}, 1);
    check("drop_busy", {31'd0, busy}, 0);
    check("drop_index", {28'd0, current_index}, m_idx);
    @(negedge clock_in);
    check("drop_idle_step", {31'd0, step_divisor}, 0);
    check("drop_idle_ready", {31'd0, req_ready}, 1);

    // Reset in SETTLE after the 2nd of 5 pulses.
    reset = 1'b1;
    @(negedge clock_in);
    reset = 1'b0;
    m_idx = 0;
    run_request(5, 25, -1);
    reset = 1'b1;
    @(negedge clock_in);
    reset = 1'b0;
    check("mid_rst_step", {31'd0, step_divisor}, 0);
    check("mid_rst_index", {28'd0, current_index}, 0);
    check("mid_rst_ready", {31'd0, req_ready}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    @(negedge clock_in);
    check("mid_rst_done2", {31'd0, done}, 0);
    check("mid_rst_step2", {31'd0, step_divisor}, 0);
    m_idx = 0;
    run_request(2, 1000, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
